// File: rtl/mfp_intc.sv
// MFP-style prioritised interrupt controller: edge/level sources, enable, pending,
// in-service and mask registers, vectored acknowledge with spurious detection.
module mfp_intc #(
   parameter int unsigned N    = 16,
   parameter int unsigned IDXW = 4
) (
   input  logic          clk_32,
   input  logic          reset,
   input  logic [N-1:0]  src,
   input  logic          wr,
   input  logic          rd,
   input  logic [2:0]    addr,
   input  logic [N-1:0]  din,
   output logic [N-1:0]  dout,
   output logic          irq,
   input  logic          iack,
   output logic [7:0]    vec,
   output logic          spurious
);

   localparam logic [2:0] A_IER = 3'd0;
   localparam logic [2:0] A_IPR = 3'd1;
   localparam logic [2:0] A_ISR = 3'd2;
   localparam logic [2:0] A_IMR = 3'd3;
   localparam logic [2:0] A_LVL = 3'd4;
   localparam logic [2:0] A_VR  = 3'd5;
   localparam logic [2:0] A_RAW = 3'd6;
   localparam int unsigned RW = (N > 8) ? N : 8;

   logic [N-1:0]    ier, ipr, isr, imr, lvl, src_q;
   logic [7:0]      vr;
   logic            iack_q;

   logic [N-1:0]    pend, edge_det, ack_onehot;
   logic [N-1:0]    ier_nxt, ipr_keep, isr_keep, ipr_nxt, isr_nxt;
   logic [IDXW-1:0] hp, hs;
   logic            hs_none, pend_any, ack, ack_valid, irq_nxt;
   logic            wr_ier, wr_ipr, wr_isr, wr_imr, wr_lvl, wr_vr;
   logic [RW-1:0]   rd_val;

   always_comb begin
      pend     = ipr & imr;
      pend_any = |pend;
      hs_none  = ~|isr;
      hp = '0;
      hs = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (pend[i]) hp = IDXW'(i);
         if (isr[i])  hs = IDXW'(i);
      end
      irq_nxt = pend_any && (hs_none || (hp > hs));
   end

   always_comb begin
      wr_ier = wr && (addr == A_IER);
      wr_ipr = wr && (addr == A_IPR);
      wr_isr = wr && (addr == A_ISR);
      wr_imr = wr && (addr == A_IMR);
      wr_lvl = wr && (addr == A_LVL);
      wr_vr  = wr && (addr == A_VR);

      ack       = iack & ~iack_q;
      ack_valid = ack & pend_any;
      ack_onehot = '0;
      if (ack_valid) ack_onehot[hp] = 1'b1;

      ier_nxt  = wr_ier ? din : ier;
      ipr_keep = wr_ipr ? din : '1;
      isr_keep = wr_isr ? din : '1;
      edge_det = src & ~src_q;

      // Clears are applied first and set sources ORed last, so a new edge or
      // acknowledge wins over a same-cycle clear of that bit.
      ipr_nxt = (lvl & src & ier_nxt)
              | (~lvl & ((ipr & ier_nxt & ipr_keep & ~ack_onehot) | (edge_det & ier)));
      isr_nxt = (isr & isr_keep) | ({N{vr[3]}} & ack_onehot);
   end

   always_comb begin
      rd_val = '0;
      case (addr)
         A_IER:   rd_val[N-1:0] = ier;
         A_IPR:   rd_val[N-1:0] = ipr;
         A_ISR:   rd_val[N-1:0] = isr;
         A_IMR:   rd_val[N-1:0] = imr;
         A_LVL:   rd_val[N-1:0] = lvl;
         A_VR:    rd_val[7:0]   = vr;
         A_RAW:   rd_val[N-1:0] = src_q;
         default: rd_val = '0;
      endcase
   end

   always_ff @(posedge clk_32) begin
      if (reset) begin
         ier      <= '0;
         ipr      <= '0;
         isr      <= '0;
         imr      <= '0;
         lvl      <= '0;
         vr       <= '0;
         src_q    <= '0;
         iack_q   <= 1'b0;
         irq      <= 1'b0;
         dout     <= '0;
         vec      <= '0;
         spurious <= 1'b0;
      end else begin
         src_q  <= src;
         iack_q <= iack;
         ier    <= ier_nxt;
         ipr    <= ipr_nxt;
         isr    <= isr_nxt;
         if (wr_imr) imr <= din;
         if (wr_lvl) lvl <= din;
         if (wr_vr)  vr  <= din[7:0];
         irq  <= irq_nxt;
         dout <= rd ? rd_val[N-1:0] : '0;
         if (ack) begin
            if (pend_any) begin
               vec      <= {vr[7:IDXW], hp};
               spurious <= 1'b0;
            end else begin
               vec      <= 8'h18;
               spurious <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_mfp_intc.sv
// Directed self-checking bench for mfp_intc (16-channel and 32-channel instances).
module tb_mfp_intc;

   logic        clk_32 = 1'b0;
   logic        reset  = 1'b1;

   logic [15:0] src16 = '0, din16 = '0, dout16;
   logic        wr16 = 1'b0, rd16 = 1'b0, iack16 = 1'b0, irq16, spurious16;
   logic [2:0]  addr16 = '0;
   logic [7:0]  vec16;

   logic [31:0] src32 = '0, din32 = '0, dout32;
   logic        wr32 = 1'b0, rd32 = 1'b0, iack32 = 1'b0, irq32, spurious32;
   logic [2:0]  addr32 = '0;
   logic [7:0]  vec32;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk_32 = ~clk_32;

   mfp_intc #(.N(16), .IDXW(4)) dut16 (
      .clk_32(clk_32), .reset(reset), .src(src16), .wr(wr16), .rd(rd16),
      .addr(addr16), .din(din16), .dout(dout16), .irq(irq16), .iack(iack16),
      .vec(vec16), .spurious(spurious16)
   );

   mfp_intc #(.N(32), .IDXW(5)) dut32 (
      .clk_32(clk_32), .reset(reset), .src(src32), .wr(wr32), .rd(rd32),
      .addr(addr32), .din(din32), .dout(dout32), .irq(irq32), .iack(iack32),
      .vec(vec32), .spurious(spurious32)
   );

   task automatic tick;
      @(posedge clk_32);
      #1;
   endtask

   task automatic w16(input logic [2:0] a, input logic [15:0] d);
      wr16 = 1'b1; addr16 = a; din16 = d;
      tick;
      wr16 = 1'b0;
   endtask

   task automatic r16(input logic [2:0] a, output logic [15:0] d);
      rd16 = 1'b1; addr16 = a;
      tick;
      d = dout16;
      rd16 = 1'b0;
   endtask

   task automatic w32(input logic [2:0] a, input logic [31:0] d);
      wr32 = 1'b1; addr32 = a; din32 = d;
      tick;
      wr32 = 1'b0;
   endtask

   task automatic r32(input logic [2:0] a, output logic [31:0] d);
      rd32 = 1'b1; addr32 = a;
      tick;
      d = dout32;
      rd32 = 1'b0;
   endtask

   task automatic test_reset;
      logic [15:0] v;
      reset = 1'b1;
      tick; tick;
      n_cmp++; if (irq16 !== 1'b0) begin n_err++; $display("FAIL reset_irq: got %b want 0", irq16); end
      n_cmp++; if (dout16 !== 16'h0000) begin n_err++; $display("FAIL reset_dout: got %h want 0000", dout16); end
      n_cmp++; if (vec16 !== 8'h00) begin n_err++; $display("FAIL reset_vec: got %h want 00", vec16); end
      n_cmp++; if (spurious16 !== 1'b0) begin n_err++; $display("FAIL reset_spurious: got %b want 0", spurious16); end
      n_cmp++; if (irq32 !== 1'b0) begin n_err++; $display("FAIL reset_irq32: got %b want 0", irq32); end
      reset = 1'b0;
      tick;
      r16(3'd0, v);
      n_cmp++; if (v !== 16'h0000) begin n_err++; $display("FAIL reset_ier: got %h want 0000", v); end
      r16(3'd5, v);
      n_cmp++; if (v !== 16'h0000) begin n_err++; $display("FAIL reset_vr: got %h want 0000", v); end
   endtask

   task automatic test_basic;
      logic [15:0] v;
      w16(3'd0, 16'h0001);
      w16(3'd3, 16'h0001);
      w16(3'd5, 16'h0048);
      r16(3'd5, v);
      n_cmp++; if (v !== 16'h0048) begin n_err++; $display("FAIL basic_vr_read: got %h want 0048", v); end
      rd16 = 1'b1; addr16 = 3'd1; src16[0] = 1'b1;
      tick;
      n_cmp++; if (irq16 !== 1'b0) begin n_err++; $display("FAIL basic_irq_t1: got %b want 0", irq16); end
      n_cmp++; if (dout16 !== 16'h0000) begin n_err++; $display("FAIL basic_ipr_t0: got %h want 0000", dout16); end
      src16[0] = 1'b0;
      tick;
      n_cmp++; if (dout16 !== 16'h0001) begin n_err++; $display("FAIL basic_ipr_t1: got %h want 0001", dout16); end
      n_cmp++; if (irq16 !== 1'b1) begin n_err++; $display("FAIL basic_irq_t2: got %b want 1", irq16); end
      rd16 = 1'b0;
      tick;
      n_cmp++; if (dout16 !== 16'h0000) begin n_err++; $display("FAIL basic_dout_idle: got %h want 0000", dout16); end
      iack16 = 1'b1;
      tick;
      n_cmp++; if (vec16 !== 8'h40) begin n_err++; $display("FAIL basic_vec: got %h want 40", vec16); end
      n_cmp++; if (spurious16 !== 1'b0) begin n_err++; $display("FAIL basic_spurious: got %b want 0", spurious16); end
      iack16 = 1'b0;
      tick;
      r16(3'd2, v);
      n_cmp++; if (v !== 16'h0001) begin n_err++; $display("FAIL basic_isr: got %h want 0001", v); end
      r16(3'd1, v);
      n_cmp++; if (v !== 16'h0000) begin n_err++; $display("FAIL basic_ipr_after_ack: got %h want 0000", v); end
      n_cmp++; if (irq16 !== 1'b0) begin n_err++; $display("FAIL basic_irq_after_ack: got %b want 0", irq16); end
      w16(3'd2, 16'hFFFE);
      r16(3'd2, v);
      n_cmp++; if (v !== 16'h0000) begin n_err++; $display("FAIL basic_isr_clear: got %h want 0000", v); end
   endtask

   task automatic test_nesting;
      logic [15:0] v;
      w16(3'd0, 16'h0228);
      w16(3'd3, 16'h0228);
      src16[5] = 1'b1; tick; src16[5] = 1'b0; tick;
      n_cmp++; if (irq16 !== 1'b1) begin n_err++; $display("FAIL nest_irq5: got %b want 1", irq16); end
      iack16 = 1'b1; tick;
      n_cmp++; if (vec16 !== 8'h45) begin n_err++; $display("FAIL nest_vec5: got %h want 45", vec16); end
      iack16 = 1'b0; tick; tick;
      n_cmp++; if (irq16 !== 1'b0) begin n_err++; $display("FAIL nest_irq_served: got %b want 0", irq16); end
      r16(3'd2, v);
      n_cmp++; if (v !== 16'h0020) begin n_err++; $display("FAIL nest_isr5: got %h want 0020", v); end
      src16[3] = 1'b1; tick; src16[3] = 1'b0; tick; tick; tick;
      n_cmp++; if (irq16 !== 1'b0) begin n_err++; $display("FAIL nest_lower_blocked: got %b want 0", irq16); end
      r16(3'd1, v);
      n_cmp++; if (v !== 16'h0008) begin n_err++; $display("FAIL nest_ipr3: got %h want 0008", v); end
      src16[9] = 1'b1; tick; src16[9] = 1'b0; tick;
      n_cmp++; if (irq16 !== 1'b1) begin n_err++; $display("FAIL nest_higher_irq: got %b want 1", irq16); end
      w16(3'd2, ~16'h0020);
      r16(3'd2, v);
      n_cmp++; if (v !== 16'h0000) begin n_err++; $display("FAIL nest_isr_clear: got %h want 0000", v); end
      w16(3'd1, 16'h0000);
   endtask

   task automatic test_level;
      logic [15:0] v;
      w16(3'd4, 16'h0004);
      w16(3'd0, 16'h0004);
      w16(3'd3, 16'h0004);
      src16[2] = 1'b1; tick; tick;
      iack16 = 1'b1; tick;
      n_cmp++; if (vec16 !== 8'h42) begin n_err++; $display("FAIL level_vec: got %h want 42", vec16); end
      iack16 = 1'b0; tick;
      w16(3'd1, 16'h0000);
      r16(3'd1, v);
      n_cmp++; if (v !== 16'h0004) begin n_err++; $display("FAIL level_ipr_held: got %h want 0004", v); end
      rd16 = 1'b1; addr16 = 3'd1; src16[2] = 1'b0;
      tick;
      n_cmp++; if (dout16 !== 16'h0004) begin n_err++; $display("FAIL level_ipr_before_drop: got %h want 0004", dout16); end
      tick;
      n_cmp++; if (dout16 !== 16'h0000) begin n_err++; $display("FAIL level_ipr_drop: got %h want 0000", dout16); end
      rd16 = 1'b0;
      w16(3'd2, 16'h0000);
      w16(3'd4, 16'h0000);
   endtask

   task automatic test_collision;
      logic [15:0] v;
      w16(3'd0, 16'h0010);
      w16(3'd3, 16'h0010);
      src16[4] = 1'b1; tick; src16[4] = 1'b0; tick;
      r16(3'd1, v);
      n_cmp++; if (v !== 16'h0010) begin n_err++; $display("FAIL coll_pre_ipr: got %h want 0010", v); end
      wr16 = 1'b1; addr16 = 3'd1; din16 = 16'hFFEF; src16[4] = 1'b1;
      tick;
      wr16 = 1'b0;
      r16(3'd1, v);
      n_cmp++; if (v !== 16'h0010) begin n_err++; $display("FAIL coll_edge_wins: got %h want 0010", v); end
      w16(3'd1, 16'hFFEF);
      r16(3'd1, v);
      n_cmp++; if (v !== 16'h0000) begin n_err++; $display("FAIL coll_plain_clear: got %h want 0000", v); end
      src16[4] = 1'b0; tick;
   endtask

   task automatic test_spurious;
      logic [15:0] v;
      src16[4] = 1'b1; tick; src16[4] = 1'b0; tick; tick;
      iack16 = 1'b1; tick;
      n_cmp++; if (vec16 !== 8'h44) begin n_err++; $display("FAIL spur_valid_vec: got %h want 44", vec16); end
      iack16 = 1'b0; tick;
      iack16 = 1'b1; tick;
      n_cmp++; if (vec16 !== 8'h18) begin n_err++; $display("FAIL spur_vec: got %h want 18", vec16); end
      n_cmp++; if (spurious16 !== 1'b1) begin n_err++; $display("FAIL spur_flag: got %b want 1", spurious16); end
      iack16 = 1'b0; tick;
      r16(3'd2, v);
      n_cmp++; if (v !== 16'h0010) begin n_err++; $display("FAIL spur_isr_kept: got %h want 0010", v); end
      w16(3'd2, 16'h0000);
      w16(3'd3, 16'h0000);
      src16[4] = 1'b1; tick; src16[4] = 1'b0; tick; tick; tick;
      n_cmp++; if (irq16 !== 1'b0) begin n_err++; $display("FAIL mask_irq: got %b want 0", irq16); end
      iack16 = 1'b1; tick;
      n_cmp++; if (spurious16 !== 1'b1) begin n_err++; $display("FAIL mask_ack_spurious: got %b want 1", spurious16); end
      iack16 = 1'b0; tick;
      r16(3'd1, v);
      n_cmp++; if (v !== 16'h0010) begin n_err++; $display("FAIL mask_ipr_kept: got %h want 0010", v); end
   endtask

   task automatic test_aeoi;
      logic [15:0] v;
      w16(3'd3, 16'h0010);
      w16(3'd5, 16'h0040);
      iack16 = 1'b1; tick;
      n_cmp++; if (vec16 !== 8'h44) begin n_err++; $display("FAIL aeoi_vec: got %h want 44", vec16); end
      n_cmp++; if (spurious16 !== 1'b0) begin n_err++; $display("FAIL aeoi_spurious: got %b want 0", spurious16); end
      iack16 = 1'b0; tick;
      r16(3'd2, v);
      n_cmp++; if (v !== 16'h0000) begin n_err++; $display("FAIL aeoi_isr: got %h want 0000", v); end
      r16(3'd1, v);
      n_cmp++; if (v !== 16'h0000) begin n_err++; $display("FAIL aeoi_ipr: got %h want 0000", v); end
   endtask

   task automatic test_wide_and_reset;
      logic [31:0] v;
      logic [15:0] v16;
      w32(3'd0, 32'h8000_0000);
      w32(3'd3, 32'h8000_0000);
      w32(3'd5, 32'h0000_00A0);
      src32[31] = 1'b1; tick; src32[31] = 1'b0; tick;
      n_cmp++; if (irq32 !== 1'b1) begin n_err++; $display("FAIL wide_irq: got %b want 1", irq32); end
      iack32 = 1'b1; tick;
      n_cmp++; if (vec32 !== 8'hBF) begin n_err++; $display("FAIL wide_vec: got %h want BF", vec32); end
      iack32 = 1'b0; tick;
      src32[31] = 1'b1; tick; src32[31] = 1'b0; tick;
      n_cmp++; if (irq32 !== 1'b1) begin n_err++; $display("FAIL wide_irq_again: got %b want 1", irq32); end
      src16[4] = 1'b1; tick; src16[4] = 1'b0; tick;
      n_cmp++; if (irq16 !== 1'b1) begin n_err++; $display("FAIL rst_pre_irq16: got %b want 1", irq16); end
      rd16 = 1'b1; addr16 = 3'd1; rd32 = 1'b1; addr32 = 3'd1;
      reset = 1'b1;
      tick;
      n_cmp++; if (irq32 !== 1'b0) begin n_err++; $display("FAIL rst_irq32: got %b want 0", irq32); end
      n_cmp++; if (vec32 !== 8'h00) begin n_err++; $display("FAIL rst_vec32: got %h want 00", vec32); end
      n_cmp++; if (dout32 !== 32'h0) begin n_err++; $display("FAIL rst_dout32: got %h want 0", dout32); end
      n_cmp++; if (spurious32 !== 1'b0) begin n_err++; $display("FAIL rst_spurious32: got %b want 0", spurious32); end
      n_cmp++; if (irq16 !== 1'b0) begin n_err++; $display("FAIL rst_irq16: got %b want 0", irq16); end
      n_cmp++; if (vec16 !== 8'h00) begin n_err++; $display("FAIL rst_vec16: got %h want 00", vec16); end
      n_cmp++; if (dout16 !== 16'h0) begin n_err++; $display("FAIL rst_dout16: got %h want 0", dout16); end
      reset = 1'b0; rd16 = 1'b0; rd32 = 1'b0;
      tick;
      r32(3'd1, v);
      n_cmp++; if (v !== 32'h0) begin n_err++; $display("FAIL rst_ipr32: got %h want 0", v); end
      r16(3'd1, v16);
      n_cmp++; if (v16 !== 16'h0) begin n_err++; $display("FAIL rst_ipr16: got %h want 0", v16); end
      n_cmp++; if (irq32 !== 1'b0) begin n_err++; $display("FAIL rst_irq32_after: got %b want 0", irq32); end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_nesting;
      test_level;
      test_collision;
      test_spurious;
      test_aeoi;
      test_wide_and_reset;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1);
   end

endmodule
